// File: rtl/multiword_add_sequencer.sv
// Sequenced wide adder: a WIDTH-bit sum is built one CHUNK-bit slice per cycle
// through a single ripple_adder_generic, with the carry held in a register between slices.

interface full_adder_intf #(parameter int BITWIDTH = 8);
    logic [BITWIDTH-1:0] a;
    logic [BITWIDTH-1:0] b;
    logic                cin;
    logic [BITWIDTH-1:0] sum;
    logic                cout;

    modport adder  (input a, input b, input cin, output sum, output cout);
    modport driver (output a, output b, output cin, input sum, input cout);
endinterface

module ripple_adder_generic #(
    parameter int BITWIDTH = 8
) (
    full_adder_intf.adder bus
);
    logic [BITWIDTH-1:0] prop;
    logic [BITWIDTH-1:0] gen;
    logic [BITWIDTH-1:0] sum_w;
    logic                cout_w;

    for (genvar gi = 0; gi < BITWIDTH; gi++) begin : g_pg
        assign prop[gi] = bus.a[gi] ^ bus.b[gi];
        assign gen[gi]  = bus.a[gi] & bus.b[gi];
    end

    // The chain is walked in a loop so the carry stays a local variable.
    always_comb begin
        logic c;
        c     = bus.cin;
        sum_w = '0;
        for (int i = 0; i < BITWIDTH; i++) begin
            sum_w[i] = prop[i] ^ c;
            c        = gen[i] | (prop[i] & c);
        end
        cout_w = c;
    end

    assign bus.sum  = sum_w;
    assign bus.cout = cout_w;
endmodule

module multiword_add_sequencer #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);
    localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
    localparam int NUM_CHUNKS = WIDTH / CHUNK_SAFE;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    if (CHUNK < 1) begin : g_bad_chunk
        $error("multiword_add_sequencer: CHUNK must be at least 1");
    end else if (WIDTH % CHUNK_SAFE != 0) begin : g_bad_width
        $error("multiword_add_sequencer: WIDTH must be a multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             carry_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] result_reg;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             busy_reg;
    int               slice_lsb;

    full_adder_intf #(.BITWIDTH(CHUNK_SAFE)) chunk_bus ();

    assign slice_lsb     = int'(idx_reg) * CHUNK_SAFE;
    assign chunk_bus.a   = a_reg[slice_lsb +: CHUNK_SAFE];
    assign chunk_bus.b   = b_reg[slice_lsb +: CHUNK_SAFE];
    assign chunk_bus.cin = carry_reg;

    ripple_adder_generic #(.BITWIDTH(CHUNK_SAFE)) u_chunk_adder (
        .bus (chunk_bus)
    );

    // in_ready is a flop, so it comes up one cycle after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            carry_reg     <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            result_reg    <= '0;
            in_ready_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid && in_ready_reg) begin
                        a_reg        <= in_a;
                        b_reg        <= in_b;
                        carry_reg    <= in_cin;
                        idx_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= BUSY;
                    end else begin
                        in_ready_reg <= 1'b1;
                    end
                end
                BUSY: begin
                    result_reg[slice_lsb +: CHUNK_SAFE] <= chunk_bus.sum;
                    carry_reg                           <= chunk_bus.cout;
                    if (idx_reg == LAST_IDX) begin
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out_sum   = result_reg;
    assign out_cout  = carry_reg;
    assign busy      = busy_reg;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Scoreboard bench for multiword_add_sequencer: 32/8, 8/8 and 8/1 configurations.
module tb_multiword_add_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic        in_valid0, in_ready0, in_cin0, out_valid0, out_ready0, out_cout0, busy0;
    logic [31:0] in_a0, in_b0, out_sum0;
    logic        in_valid1, in_ready1, in_cin1, out_valid1, out_ready1, out_cout1, busy1;
    logic [7:0]  in_a1, in_b1, out_sum1;
    logic        in_valid2, in_ready2, in_cin2, out_valid2, out_ready2, out_cout2, busy2;
    logic [7:0]  in_a2, in_b2, out_sum2;

    logic [32:0] q0[$];
    logic [32:0] q1[$];
    logic [32:0] q2[$];

    multiword_add_sequencer #(.WIDTH(32), .CHUNK(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_a(in_a0), .in_b(in_b0), .in_cin(in_cin0), .out_valid(out_valid0),
        .out_ready(out_ready0), .out_sum(out_sum0), .out_cout(out_cout0), .busy(busy0)
    );
    multiword_add_sequencer #(.WIDTH(8), .CHUNK(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_sum(out_sum1), .out_cout(out_cout1), .busy(busy1)
    );
    multiword_add_sequencer #(.WIDTH(8), .CHUNK(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_a(in_a2), .in_b(in_b2), .in_cin(in_cin2), .out_valid(out_valid2),
        .out_ready(out_ready2), .out_sum(out_sum2), .out_cout(out_cout2), .busy(busy2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h at %0t", name, act, $time);
        end
    endtask

    task automatic set_in(input int d, input logic v, input logic [31:0] a, input logic [31:0] b,
                          input logic c);
        case (d)
            0: begin in_valid0 = v; in_a0 = a;      in_b0 = b;      in_cin0 = c; end
            1: begin in_valid1 = v; in_a1 = a[7:0]; in_b1 = b[7:0]; in_cin1 = c; end
            default: begin in_valid2 = v; in_a2 = a[7:0]; in_b2 = b[7:0]; in_cin2 = c; end
        endcase
    endtask

    function automatic logic get_ready(input int d);
        return (d == 0) ? in_ready0 : (d == 1) ? in_ready1 : in_ready2;
    endfunction

    function automatic logic get_valid(input int d);
        return (d == 0) ? out_valid0 : (d == 1) ? out_valid1 : out_valid2;
    endfunction

    // Returns in cycle T+1 (one step past the accepting edge) with the expectation queued.
    task automatic issue(input int d, input logic [31:0] a, input logic [31:0] b, input logic c);
        int n;
        logic [32:0] exp;
        n = 0;
        set_in(d, 1'b1, a, b, c);
        @(negedge clk);
        while (!get_ready(d) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            check("accept_timeout", 64'(n), 64'(0));
            set_in(d, 1'b0, a, b, c);
            return;
        end
        @(posedge clk);
        #1;
        set_in(d, 1'b0, ~a, ~b, ~c);
        exp = {1'b0, a} + {1'b0, b} + {32'b0, c};
        case (d)
            0: q0.push_back(exp);
            1: q1.push_back(exp);
            default: q2.push_back(exp);
        endcase
        $display("issue dut%0d a=0x%0h b=0x%0h cin=%0d expect=0x%0h", d, a, b, c, exp);
    endtask

    task automatic wait_result(input int d, input int exp_lat);
        int k;
        k = 1;
        while (!get_valid(d) && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check($sformatf("latency_dut%0d", d), 64'(k), 64'(exp_lat));
    endtask

    always @(negedge clk) begin : mon0
        logic [32:0] e;
        if (rst_n && out_valid0 && out_ready0) begin
            if (q0.size() == 0) check("unexpected_out0", {31'b0, out_cout0, out_sum0}, 64'hDEAD);
            else begin
                e = q0.pop_front();
                check("sum_dut0", {31'b0, out_cout0, out_sum0}, {31'b0, e});
            end
        end
    end

    always @(negedge clk) begin : mon1
        logic [32:0] e;
        if (rst_n && out_valid1 && out_ready1) begin
            if (q1.size() == 0) check("unexpected_out1", {55'b0, out_cout1, out_sum1}, 64'hDEAD);
            else begin
                e = q1.pop_front();
                check("sum_dut1", {55'b0, out_cout1, out_sum1}, {31'b0, e});
            end
        end
    end

    always @(negedge clk) begin : mon2
        logic [32:0] e;
        if (rst_n && out_valid2 && out_ready2) begin
            if (q2.size() == 0) check("unexpected_out2", {55'b0, out_cout2, out_sum2}, 64'hDEAD);
            else begin
                e = q2.pop_front();
                check("sum_dut2", {55'b0, out_cout2, out_sum2}, {31'b0, e});
            end
        end
    end

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 3; d++) set_in(d, 1'b0, 32'h0, 32'h0, 1'b0);
        out_ready0 = 1'b1;
        out_ready1 = 1'b1;
        out_ready2 = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid0), 64'(0));
        check("rst_in_ready", 64'(in_ready0), 64'(0));
        check("rst_busy", 64'(busy0), 64'(0));
        check("rst_sum", {31'b0, out_cout0, out_sum0}, 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        issue(0, 32'h0000_0001, 32'h0000_0002, 1'b0);
        check("busy_first", 64'(busy0), 64'(1));
        wait_result(0, 5);
        check("busy_done", 64'(busy0), 64'(1));
        @(posedge clk);
        #1;
        check("ready_after_hs", 64'(in_ready0), 64'(1));
        check("idle_busy", 64'(busy0), 64'(0));

        issue(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        wait_result(0, 5);
        issue(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_result(0, 5);
        issue(0, 32'h1234_5678, 32'h0FED_CBA9, 1'b0);
        wait_result(0, 5);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("hold_sum", {31'b0, out_cout0, out_sum0}, 64'h0_2222_2221);
        check("hold_valid", 64'(out_valid0), 64'(0));

        // Backpressure with in_valid pulsing while DONE.
        out_ready0 = 1'b0;
        issue(0, 32'h1111_1111, 32'h2222_2222, 1'b0);
        wait_result(0, 5);
        for (int i = 0; i < 10; i++) begin
            in_valid0 = 1'(i);
            in_a0 = $urandom;
            in_b0 = $urandom;
            in_cin0 = 1'($urandom);
            @(posedge clk);
            #1;
            check("bp_hold", {30'b0, out_valid0, in_ready0, out_cout0, out_sum0},
                  {30'b0, 1'b1, 1'b0, 1'b0, 32'h3333_3333});
        end
        in_valid0 = 1'b0;
        out_ready0 = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_ready", 64'(in_ready0), 64'(1));

        // Asynchronous reset in the second BUSY cycle.
        issue(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        q0.delete();
        check("abort_valid", 64'(out_valid0), 64'(0));
        check("abort_sum", 64'(out_sum0), 64'(0));
        check("abort_ready", 64'(in_ready0), 64'(0));
        check("abort_busy", 64'(busy0), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        issue(0, 32'h0000_0005, 32'h0000_0007, 1'b0);
        wait_result(0, 5);

        issue(1, 32'h80, 32'h80, 1'b0);
        wait_result(1, 2);
        issue(2, 32'hAA, 32'h55, 1'b1);
        wait_result(2, 9);
        issue(2, 32'h0F, 32'h01, 1'b0);
        wait_result(2, 9);

        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("queues_drained", 64'(q0.size() + q1.size() + q2.size()), 64'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
